// File: rtl/regs_dbg_pkg.sv
// Shared types for the picoMIPS register-file debug dump reader.
// Holds the FSM state encoding and register-address helpers.
package regs_dbg_pkg;

    localparam int NREGS = 32;

    typedef logic [4:0] reg_addr_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } dump_state_t;

    // Next register address, wrapping from the top of the file back to r0.
    function automatic reg_addr_t next_addr(input reg_addr_t a);
        return reg_addr_t'((int'(a) + 1) % NREGS);
    endfunction

endpackage

// File: rtl/regs_dump.sv
// Debug reader that walks an address range of the register file through read
// port 1, one register per borrowed cycle, and streams (address, value) words out.
module regs_dump
    import regs_dbg_pkg::*;
#(
    parameter int n  = 8,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    input  logic [AW-1:0] first,
    input  logic [AW-1:0] last,
    output logic          port_req,
    output logic [AW-1:0] rd_addr,
    input  logic [n-1:0]  rd_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_addr,
    output logic [n-1:0]  out_data,
    output logic          busy,
    output logic          done
);

    dump_state_t   r_state;
    dump_state_t   w_state_next;
    logic [AW-1:0] r_idx;
    logic [AW-1:0] w_idx_next;
    logic [AW-1:0] r_last_q;
    logic [AW-1:0] w_last_next;
    logic          r_out_valid;
    logic          w_out_valid_next;
    logic [AW-1:0] r_out_addr;
    logic [AW-1:0] w_out_addr_next;
    logic [n-1:0]  r_out_data;
    logic [n-1:0]  w_out_data_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_last_q    <= '0;
            r_out_valid <= 1'b0;
            r_out_addr  <= '0;
            r_out_data  <= '0;
        end else begin
            r_state     <= w_state_next;
            r_idx       <= w_idx_next;
            r_last_q    <= w_last_next;
            r_out_valid <= w_out_valid_next;
            r_out_addr  <= w_out_addr_next;
            r_out_data  <= w_out_data_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_idx_next       = r_idx;
        w_last_next      = r_last_q;
        w_out_valid_next = r_out_valid;
        w_out_addr_next  = r_out_addr;
        w_out_data_next  = r_out_data;

        // Abort outranks everything, including a handshake landing on the same edge.
        if (abort && (r_state != IDLE)) begin
            w_state_next     = IDLE;
            w_out_valid_next = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        w_idx_next   = first;
                        w_last_next  = last;
                        w_state_next = READ;
                    end
                end
                READ: begin
                    w_out_data_next  = rd_data;
                    w_out_addr_next  = r_idx;
                    w_out_valid_next = 1'b1;
                    w_state_next     = HOLD;
                end
                HOLD: begin
                    if (r_out_valid && out_ready) begin
                        w_out_valid_next = 1'b0;
                        if (r_idx == r_last_q) begin
                            w_state_next = DONE;
                        end else begin
                            w_idx_next   = next_addr(r_idx);
                            w_state_next = READ;
                        end
                    end
                end
                DONE: begin
                    w_state_next = IDLE;
                end
                default: begin
                    w_state_next = IDLE;
                end
            endcase
        end
    end

    // Port ownership is a pure function of state so out_ready never reaches Raddr1 muxing.
    assign port_req  = (r_state == READ);
    assign rd_addr   = r_idx;
    assign out_valid = r_out_valid;
    assign out_addr  = r_out_addr;
    assign out_data  = r_out_data;
    assign busy      = (r_state != IDLE);
    assign done      = (r_state == DONE);

endmodule

// File: tb/tb_regs_dump.sv
// Scoreboard bench for regs_dump: stimulus pushes expected words, a monitor
// pops and compares on every accepted handshake.
module tb_regs_dump;

    localparam int N  = 8;
    localparam int AW = 5;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [N-1:0]  d;
    } word_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [AW-1:0] first = '0;
    logic [AW-1:0] last = '0;
    logic          port_req;
    logic [AW-1:0] rd_addr;
    logic [N-1:0]  rd_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [AW-1:0] out_addr;
    logic [N-1:0]  out_data;
    logic          busy;
    logic          done;

    logic          ready_val = 1'b0;
    logic          ready_rand = 1'b0;
    logic [N-1:0]  rf [32];
    word_t         exp_q [$];

    int n_checks = 0;
    int n_errors = 0;
    int hs_cnt = 0;
    int pr_cnt = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    // r0 is hardwired to zero in the register file regardless of writes.
    assign rd_data = (rd_addr == '0) ? '0 : rf[rd_addr];

    regs_dump #(.n(N), .AW(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .first     (first),
        .last      (last),
        .port_req  (port_req),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_addr  (out_addr),
        .out_data  (out_data),
        .busy      (busy),
        .done      (done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    task automatic push(input logic [AW-1:0] a, input logic [N-1:0] d);
        word_t w;
        w.a = a;
        w.d = d;
        exp_q.push_back(w);
    endtask

    task automatic do_start(input logic [AW-1:0] f, input logic [AW-1:0] l);
        @(posedge clk);
        #1;
        first = f;
        last  = l;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int k;
        k = 0;
        while (busy && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(name, {31'd0, busy}, 32'd0);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_port_req"}, {31'd0, port_req}, 32'd0);
        chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_rd_addr"}, {27'd0, rd_addr}, 32'd0);
        chk({tag, "_out_addr"}, {27'd0, out_addr}, 32'd0);
        chk({tag, "_out_data"}, {24'd0, out_data}, 32'd0);
    endtask

    // Ready driver: sole writer of out_ready, changes just after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = ready_rand ? 1'($urandom_range(0, 1)) : ready_val;
        end
    end

    // Monitor: handshake scoreboard, hold-stability check, event counters.
    initial begin
        logic          pend;
        logic [AW-1:0] pa;
        logic [N-1:0]  pd;
        word_t         w;
        pend = 1'b0;
        pa   = '0;
        pd   = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                pend = 1'b0;
            end else begin
                if (port_req) pr_cnt++;
                if (done) done_cnt++;
                if (out_valid && pend) begin
                    chk("hold_addr", {27'd0, out_addr}, {27'd0, pa});
                    chk("hold_data", {24'd0, out_data}, {24'd0, pd});
                end
                if (out_valid && out_ready && !abort) begin
                    hs_cnt++;
                    $display("word addr=%0d data=%02h", out_addr, out_data);
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_word: got addr %0d data %02h, expected none", out_addr, out_data);
                    end else begin
                        w = exp_q.pop_front();
                        chk("word_addr", {27'd0, out_addr}, {27'd0, w.a});
                        chk("word_data", {24'd0, out_data}, {24'd0, w.d});
                    end
                end
                pend = out_valid && !(out_ready && !abort);
                pa   = out_addr;
                pd   = out_data;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int p0;
        int d0;
        int h0;
        for (int i = 0; i < 32; i++) rf[i] = 8'hE0 + 8'(i);

        // Reset state
        #3;
        chk_zero_outputs("reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        ready_val = 1'b1;
        repeat (2) @(posedge clk);

        // Dump r1..r3 with ready high: cycle-accurate timing
        rf[1] = 8'h11;
        rf[2] = 8'h22;
        rf[3] = 8'h33;
        push(5'd1, 8'h11);
        push(5'd2, 8'h22);
        push(5'd3, 8'h33);
        p0 = pr_cnt;
        d0 = done_cnt;
        do_start(5'd1, 5'd3);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk($sformatf("t1_port_req_c%0d", k), {31'd0, port_req}, {31'd0, (k == 1 || k == 3 || k == 5)});
            chk($sformatf("t1_out_valid_c%0d", k), {31'd0, out_valid}, {31'd0, (k == 2 || k == 4 || k == 6)});
            chk($sformatf("t1_done_c%0d", k), {31'd0, done}, {31'd0, (k == 7)});
            chk($sformatf("t1_busy_c%0d", k), {31'd0, busy}, {31'd0, (k <= 7)});
        end
        chk("t1_port_req_cycles", pr_cnt - p0, 32'd3);
        chk("t1_done_pulses", done_cnt - d0, 32'd1);
        chk("t1_queue_empty", exp_q.size(), 32'd0);

        // Wrapping range 30..1, r0 reads as zero despite a write
        rf[30] = 8'hAA;
        rf[31] = 8'hBB;
        rf[0]  = 8'h5A;
        rf[1]  = 8'hCC;
        push(5'd30, 8'hAA);
        push(5'd31, 8'hBB);
        push(5'd0, 8'h00);
        push(5'd1, 8'hCC);
        h0 = hs_cnt;
        d0 = done_cnt;
        do_start(5'd30, 5'd1);
        wait_idle(40, "t2_timeout");
        @(negedge clk);
        chk("t2_words", hs_cnt - h0, 32'd4);
        chk("t2_done_pulses", done_cnt - d0, 32'd1);
        chk("t2_queue_empty", exp_q.size(), 32'd0);

        // Single word with ready held low for ten cycles
        ready_val = 1'b0;
        repeat (3) @(posedge clk);
        rf[5] = 8'h55;
        push(5'd5, 8'h55);
        p0 = pr_cnt;
        do_start(5'd5, 5'd5);
        @(negedge clk);
        chk("t3_port_req_c1", {31'd0, port_req}, 32'd1);
        for (int k = 2; k <= 11; k++) begin
            @(negedge clk);
            chk($sformatf("t3_out_valid_c%0d", k), {31'd0, out_valid}, 32'd1);
            chk($sformatf("t3_out_data_c%0d", k), {24'd0, out_data}, 32'h55);
        end
        ready_val = 1'b1;
        @(negedge clk);
        chk("t3_valid_ready_cycle", {31'd0, out_valid}, 32'd1);
        chk("t3_no_done_yet", {31'd0, done}, 32'd0);
        @(negedge clk);
        chk("t3_done_after_ready", {31'd0, done}, 32'd1);
        chk("t3_valid_dropped", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        chk("t3_busy_cleared", {31'd0, busy}, 32'd0);
        chk("t3_port_req_cycles", pr_cnt - p0, 32'd1);
        chk("t3_queue_empty", exp_q.size(), 32'd0);

        // Full 0..31 dump with random backpressure
        for (int i = 1; i < 32; i++) rf[i] = 8'(i * 9 + 1);
        for (int i = 0; i < 32; i++) push(5'(i), (i == 0) ? 8'h00 : rf[i]);
        h0 = hs_cnt;
        d0 = done_cnt;
        ready_rand = 1'b1;
        do_start(5'd0, 5'd31);
        wait_idle(600, "t4_timeout");
        ready_rand = 1'b0;
        ready_val = 1'b1;
        @(negedge clk);
        chk("t4_words", hs_cnt - h0, 32'd32);
        chk("t4_done_pulses", done_cnt - d0, 32'd1);
        chk("t4_queue_empty", exp_q.size(), 32'd0);
        repeat (2) @(posedge clk);

        // Abort during HOLD of the second word; handshake in that cycle is lost
        rf[1] = 8'h11;
        rf[2] = 8'h22;
        rf[3] = 8'h33;
        push(5'd1, 8'h11);
        h0 = hs_cnt;
        d0 = done_cnt;
        do_start(5'd1, 5'd3);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        abort = 1'b1;
        @(negedge clk);
        chk("t5_hold_valid", {31'd0, out_valid}, 32'd1);
        chk("t5_hold_addr", {27'd0, out_addr}, 32'd2);
        @(posedge clk);
        #1;
        abort = 1'b0;
        @(negedge clk);
        chk("t5_valid_after_abort", {31'd0, out_valid}, 32'd0);
        chk("t5_busy_after_abort", {31'd0, busy}, 32'd0);
        chk("t5_port_req_after_abort", {31'd0, port_req}, 32'd0);
        repeat (3) @(negedge clk);
        chk("t5_no_done", done_cnt - d0, 32'd0);
        chk("t5_words", hs_cnt - h0, 32'd1);
        chk("t5_queue_empty", exp_q.size(), 32'd0);
        push(5'd1, 8'h11);
        d0 = done_cnt;
        do_start(5'd1, 5'd1);
        wait_idle(20, "t5_restart_timeout");
        @(negedge clk);
        chk("t5_restart_done", done_cnt - d0, 32'd1);
        chk("t5_restart_queue_empty", exp_q.size(), 32'd0);

        // Second start mid-dump is ignored; reset mid-READ clears outputs without a clock
        push(5'd1, 8'h11);
        push(5'd2, 8'h22);
        push(5'd3, 8'h33);
        d0 = done_cnt;
        do_start(5'd1, 5'd3);
        @(negedge clk);
        @(posedge clk);
        #1;
        first = 5'd9;
        last  = 5'd9;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("t6_port_req_c3", {31'd0, port_req}, 32'd1);
        chk("t6_rd_addr_c3", {27'd0, rd_addr}, 32'd2);
        #1;
        reset = 1'b1;
        #1;
        chk_zero_outputs("t6_async_reset");
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("t6_idle_after_reset", {31'd0, busy}, 32'd0);
        chk("t6_no_done", done_cnt - d0, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
